// File: rtl/vec_pkg.sv
// Shared types for the vector write-back path: output-stage state and requester limit.
package vec_pkg;

    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_e;

    localparam int NREQ_MAX = 8;

endpackage

// File: rtl/vec_wb_arbiter_if.sv
// Requester and register-file write-port bundle for vec_wb_arbiter.
// req_lock exists only when VEC_WB_LOCK_EN is defined.
interface vec_wb_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int NREQ  = 3,
    parameter int AW    = 4
) ();
    localparam int SRCW = $clog2(NREQ);

    logic [NREQ-1:0]                        req_valid;
    logic [NREQ-1:0]                        req_ready;
    logic [NREQ-1:0][AW-1:0]                req_addr;
    logic [NREQ-1:0][DEPTH-1:0][WIDTH-1:0]  req_data;
`ifdef VEC_WB_LOCK_EN
    logic [NREQ-1:0]                        req_lock;
`endif
    logic                                   wb_valid;
    logic                                   wb_ready;
    logic [AW-1:0]                          wb_addr;
    logic [DEPTH-1:0][WIDTH-1:0]            wb_data;
    logic [SRCW-1:0]                        wb_src;

    modport slave (
`ifdef VEC_WB_LOCK_EN
        input  req_lock,
`endif
        input  req_valid, req_addr, req_data, wb_ready,
        output req_ready, wb_valid, wb_addr, wb_data, wb_src
    );

    modport master (
`ifdef VEC_WB_LOCK_EN
        output req_lock,
`endif
        output req_valid, req_addr, req_data, wb_ready,
        input  req_ready, wb_valid, wb_addr, wb_data, wb_src
    );

endinterface

// File: rtl/vec_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_pick
    import vec_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  ptr,
    output logic [$clog2(N)-1:0]  grant,
    output logic                  any_grant
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    // Walk from the farthest offset back toward ptr so the nearest hit wins.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = NREQ_MAX - 1; k >= 0; k--) begin
            if (k < N) begin
                idx = IW'((int'(ptr) + k) % N);
                if (req[idx]) begin
                    grant     = idx;
                    any_grant = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vec_wb_arbiter.sv
// Round-robin write-back arbiter feeding one output stage to the vector register file.
// Optional requester lock for multi-register bursts: define VEC_WB_LOCK_EN.
//
//   state    | meaning
//   WB_EMPTY | output stage holds nothing, wb_valid=0
//   WB_FULL  | output stage holds a vector awaiting wb_ready
module vec_wb_arbiter
    import vec_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int NREQ  = 3,
    parameter int AW    = 4,
    parameter int CW    = 16
) (
    input  logic           clk,
    input  logic           reset,
    vec_wb_if.slave        bus,
    output logic [CW-1:0]  contention_cnt
);
    localparam int SRCW = $clog2(NREQ);

    wb_state_e                    state, state_nxt;
    logic [SRCW-1:0]              rr_ptr, rr_ptr_nxt;
    logic [SRCW-1:0]              grant, grant_inc;
    logic                         any_grant, can_accept, accept, multi_req;
    logic [NREQ-1:0]              req_eff, ready_c;
    logic [AW-1:0]                addr_q;
    logic [DEPTH-1:0][WIDTH-1:0]  data_q;
    logic [SRCW-1:0]              src_q;
    logic [CW-1:0]                cnt_q;

`ifdef VEC_WB_LOCK_EN
    logic                         locked, locked_nxt;
    logic [SRCW-1:0]              lock_src, lock_src_nxt;

    // While locked, only the owner is visible to the picker, idle or not.
    assign req_eff = locked ? (bus.req_valid & (NREQ'(1) << lock_src)) : bus.req_valid;
`else
    assign req_eff = bus.req_valid;
`endif

    rr_pick #(.N(NREQ)) u_pick (
        .req       (req_eff),
        .ptr       (rr_ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    assign grant_inc = (grant == SRCW'(NREQ - 1)) ? '0 : grant + SRCW'(1);
    assign multi_req = $countones(bus.req_valid) >= 2;

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        ready_c    = '0;
`ifdef VEC_WB_LOCK_EN
        locked_nxt   = locked;
        lock_src_nxt = lock_src;
`endif
        can_accept = (state == WB_EMPTY) || bus.wb_ready;
        accept     = can_accept && any_grant;
        if (accept) begin
            ready_c[grant] = 1'b1;
            state_nxt      = WB_FULL;
`ifdef VEC_WB_LOCK_EN
            if (bus.req_lock[grant]) begin
                locked_nxt   = 1'b1;
                lock_src_nxt = grant;
            end else begin
                locked_nxt = 1'b0;
                rr_ptr_nxt = grant_inc;
            end
`else
            rr_ptr_nxt = grant_inc;
`endif
        end else if (state == WB_FULL && bus.wb_ready) begin
            state_nxt = WB_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= WB_EMPTY;
            rr_ptr <= '0;
            addr_q <= '0;
            data_q <= '0;
            src_q  <= '0;
            cnt_q  <= '0;
`ifdef VEC_WB_LOCK_EN
            locked   <= 1'b0;
            lock_src <= '0;
`endif
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            if (accept) begin
                addr_q <= bus.req_addr[grant];
                data_q <= bus.req_data[grant];
                src_q  <= grant;
            end
            if (accept && multi_req && cnt_q != '1) begin
                cnt_q <= cnt_q + CW'(1);
            end
`ifdef VEC_WB_LOCK_EN
            locked   <= locked_nxt;
            lock_src <= lock_src_nxt;
`endif
        end
    end

    assign bus.req_ready   = ready_c;
    assign bus.wb_valid    = (state == WB_FULL);
    assign bus.wb_addr     = addr_q;
    assign bus.wb_data     = data_q;
    assign bus.wb_src      = src_q;
    assign contention_cnt  = cnt_q;

endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Self-checking bench for vec_wb_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_vec_wb_arbiter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int NREQ  = 3;
    localparam int AW    = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [CW-1:0] contention_cnt;

    always #5 clk = ~clk;

    vec_wb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .AW(AW)) bus ();

    vec_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .AW(AW), .CW(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .contention_cnt (contention_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model of the output stage and arbitration bookkeeping.
    bit                          m_full;
    logic [AW-1:0]               m_addr;
    logic [DEPTH-1:0][WIDTH-1:0] m_data;
    int                          m_src, m_ptr, m_cnt;
    bit                          m_locked;
    int                          m_owner;
    int                          last_grant;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_addr = '0; m_data = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
        m_locked = 0; m_owner = 0;
    endtask

    function automatic int model_grant();
        int i;
        if (m_full && !bus.wb_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (m_locked && i != m_owner) continue;
            if (bus.req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clock();
        int g;
        bit lk;
        g = model_grant();
        last_grant = g;
        if (reset) begin
            model_reset();
            last_grant = -1;
        end else if (g >= 0) begin
            if ($countones(bus.req_valid) >= 2 && m_cnt < CMAX) m_cnt++;
            m_addr = bus.req_addr[g];
            m_data = bus.req_data[g];
            m_src  = g;
            m_full = 1;
            lk = 0;
`ifdef VEC_WB_LOCK_EN
            lk = bus.req_lock[g];
`endif
            if (lk) begin
                m_locked = 1;
                m_owner  = g;
            end else begin
                m_locked = 0;
                m_ptr    = (g + 1) % NREQ;
            end
        end else if (m_full && bus.wb_ready) begin
            m_full = 0;
        end
    endtask

    task automatic compare();
        logic [NREQ-1:0] er;
        int g;
        g  = model_grant();
        er = (g >= 0) ? (NREQ'(1) << g) : '0;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("wb_valid", 64'(bus.wb_valid), 64'(m_full));
        chk("wb_addr", 64'(bus.wb_addr), 64'(m_addr));
        chk("wb_data", 64'(bus.wb_data), 64'(m_data));
        chk("wb_src", 64'(bus.wb_src), 64'(m_src));
        chk("contention_cnt", 64'(contention_cnt), 64'(m_cnt));
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic new_payload(input int i);
        bus.req_addr[i] = AW'($urandom_range(0, (1 << AW) - 1));
        bus.req_data[i] = $urandom();
`ifdef VEC_WB_LOCK_EN
        bus.req_lock[i] = ($urandom_range(0, 3) == 0);
`endif
    endtask

    logic [DEPTH-1:0][WIDTH-1:0] d1;

    initial begin
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.wb_ready  = 1'b0;
`ifdef VEC_WB_LOCK_EN
        bus.req_lock  = '0;
`endif
        model_reset();
        last_grant = -1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
        chk("rst_wb_src", 64'(bus.wb_src), 64'd0);
        chk("rst_cnt", 64'(contention_cnt), 64'd0);
        reset = 1'b0;

        // Reset while FULL discards the held vector.
        bus.req_valid    = 3'b001;
        bus.req_addr[0]  = 4'd5;
        bus.req_data[0]  = {8'd4, 8'd3, 8'd2, 8'd1};
        bus.wb_ready     = 1'b1;
        step();
        bus.req_valid = '0;
        bus.wb_ready  = 1'b0;
        chk("full_valid", 64'(bus.wb_valid), 64'd1);
        chk("full_addr", 64'(bus.wb_addr), 64'd5);
        chk("full_data", 64'(bus.wb_data), 64'h04030201);
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_valid", 64'(bus.wb_valid), 64'd0);
        chk("midrst_data", 64'(bus.wb_data), 64'd0);
        chk("midrst_addr", 64'(bus.wb_addr), 64'd0);
        step();
        reset = 1'b0;

        // All requesters valid: strict rotation from pointer 0.
        bus.req_valid = 3'b111;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i] = AW'(i + 1);
            bus.req_data[i] = $urandom();
        end
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_src", 64'(bus.wb_src), 64'(k % 3));
        end
        chk("rr_cnt", 64'(contention_cnt), 64'd4);

        // Backpressure holds the stage; release loads the waiting vector without a bubble.
        bus.req_valid   = 3'b010;
        bus.req_addr[1] = 4'd3;
        d1              = $urandom();
        bus.req_data[1] = d1;
        step();
        chk("bp_src", 64'(bus.wb_src), 64'd1);
        bus.req_valid   = 3'b100;
        bus.req_addr[2] = 4'd7;
        bus.wb_ready    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_addr", 64'(bus.wb_addr), 64'd3);
            chk("bp_data", 64'(bus.wb_data), 64'(d1));
        end
        bus.wb_ready = 1'b1;
        step();
        chk("bp_rel_valid", 64'(bus.wb_valid), 64'd1);
        chk("bp_rel_addr", 64'(bus.wb_addr), 64'd7);
        chk("bp_rel_src", 64'(bus.wb_src), 64'd2);

        // Lone requester 2 streams without touching the contention count.
        for (int k = 0; k < 4; k++) begin
            bus.req_data[2] = $urandom();
            step();
            chk("solo_src", 64'(bus.wb_src), 64'd2);
            chk("solo_cnt", 64'(contention_cnt), 64'd4);
        end

        // Drain with no requests.
        bus.req_valid = '0;
        step();
        chk("drain_valid", 64'(bus.wb_valid), 64'd0);

`ifdef VEC_WB_LOCK_EN
        bus.req_valid = 3'b001;
        step();
        bus.req_valid = 3'b111;
        bus.req_lock  = 3'b010;
        step();
        chk("lock_b1", 64'(bus.wb_src), 64'd1);
        bus.req_data[1] = $urandom();
        step();
        chk("lock_b2", 64'(bus.wb_src), 64'd1);
        bus.req_data[1] = $urandom();
        bus.req_lock    = 3'b000;
        step();
        chk("lock_b3", 64'(bus.wb_src), 64'd1);
        bus.req_valid = 3'b101;
        step();
        chk("lock_after", 64'(bus.wb_src), 64'd2);
`endif

        // Randomized traffic honouring the hold-until-ready protocol.
        for (int i = 0; i < NREQ; i++) new_payload(i);
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_grant == i) begin
                    bus.req_valid[i] = ($urandom_range(0, 1) == 1);
                    new_payload(i);
                end else if (bus.req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    bus.req_valid[i] = 1'b1;
                    new_payload(i);
                end
            end
            bus.wb_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                model_reset();
                step();
                reset = 1'b0;
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_wb_arbiter.md
# vec_wb_arbiter

Round-robin write-back arbiter for the vector register file write port. Up to NREQ vector producers (e.g. vector ALU, load unit, scalar-to-vector broadcast) present whole vectors with a destination register number. The arbiter grants one producer per cycle, captures its vector into a single internal output stage, and presents it to the register file with a valid/ready handshake. It sits between the execute/memory stages and the vector register file write port.

## Interface
- WIDTH, 8: bit width of one vector element
- DEPTH, 4: elements per vector
- NREQ, 3: number of requesters (2..8)
- AW, 4: register address width
- CW, 16: width of the contention counter
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  [NREQ]  requester i holds a vector
- req_ready  out  [NREQ]  requester i's vector is accepted this cycle
- req_addr  in  [NREQ][AW]  destination register per requester
- req_data  in  [NREQ][DEPTH][WIDTH]  vector payload per requester
- wb_valid  out  1  output stage holds a vector
- wb_ready  in  1  register file accepts the vector this cycle
- wb_addr  out  AW  destination register of held vector
- wb_data  out  [DEPTH][WIDTH]  held vector
- wb_src  out  $clog2(NREQ)  index of requester that produced the held vector
- contention_cnt  out  CW  saturating count of cycles with a grant and ≥2 valid requesters

## Operation
- Output stage state: EMPTY (wb_valid=0) or FULL (wb_valid=1).
- can_accept = EMPTY || wb_ready.
- Grant: first valid requester starting at rr_ptr, searching upward and wrapping modulo NREQ. At most one req_ready high per cycle; req_ready[i] = can_accept && grant==i && req_valid[i].
- On accept: wb_addr, wb_data and wb_src load from the granted requester; state becomes FULL; rr_ptr = (grant+1) mod NREQ.
- FULL && wb_ready && no accept -> EMPTY; wb_addr/wb_data/wb_src keep their old values.
- FULL && !wb_ready: all req_ready=0; wb_* outputs held stable.
- Requesters keep req_valid asserted and req_addr/req_data stable until req_ready; a dropped req_valid before acceptance is permitted and simply removes the request.
- contention_cnt increments on any cycle with an accept and popcount(req_valid) ≥ 2; saturates at 2^CW-1.
- Reset (any time, including while FULL): wb_valid=0, wb_addr=0, wb_data all elements 0, wb_src=0, rr_ptr=0, contention_cnt=0, state EMPTY. A vector held in the stage is discarded.

## Timing
- Latency: 1 cycle from req_valid&&req_ready to wb_valid with that data.
- Throughput: 1 vector/cycle while wb_ready=1.
- req_ready is combinational from req_valid, wb_ready and state; no combinational path from req_data to any output.
- Simultaneous wb_ready and accept in FULL: old vector retires and the new one loads at the same edge; wb_valid stays 1.

## Configuration
- VEC_WB_LOCK_EN defined: adds input req_lock [NREQ]. An accepted beat with req_lock[grant]=1 sets a lock on that requester; rr_ptr does not advance; while locked only that requester can be granted, and others see req_ready=0 even if the locked requester is idle. The lock clears on acceptance of a beat with req_lock=0; reset clears it. Used for multi-register loads.
- Undefined: no req_lock port; pure round-robin as above.

## Structure
- Shared package vec_pkg: wb_state_e enum (WB_EMPTY, WB_FULL); NREQ_MAX constant (8).
- Sub-module rr_pick: combinational round-robin picker (req vector, pointer -> grant index, any_grant). All state remains in vec_wb_arbiter.

## Test plan
- Reset mid-FULL: load addr 5 data {1,2,3,4}, assert reset -> wb_valid=0, wb_data {0,0,0,0}, rr_ptr=0 next cycle.
- All three requesters valid, wb_ready=1 continuously -> grants 0,1,2,0 on consecutive cycles; wb_src follows one cycle later; contention_cnt=4 after 4 cycles.
- Backpressure: FULL with addr 3, wb_ready=0 for 5 cycles -> req_ready all 0, wb_addr=3 and wb_data stable; wb_ready=1 -> next pending vector appears one cycle later, no bubble.
- Single requester 2 valid, wb_ready=1 -> one vector per cycle, wb_src=2, contention_cnt unchanged.
- Drain: FULL, wb_ready=1, no requests -> wb_valid=0 next cycle.
- With VEC_WB_LOCK_EN: requester 1 sends 3 beats, req_lock=1,1,0, requesters 0 and 2 valid -> beats from 1 accepted on 3 consecutive cycles, then requester 2 granted.
